// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side monitor for a multiplexed, active-low 7-segment display bus.
//   Each {anode, cathode} sample is registered. A pattern is captured once it
//   has been present on STABLE_CYCLES+1 consecutive edges, decoded to a 4-bit
//   code, and stored in a per-slot shadow. When every slot has been seen, the
//   shadows are published together so a partial frame is never visible.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   anode        [NUM_DIGITS] active-low slot enables (bit i = slot i)
//   cathode      [7] active-low segments, bit6..bit0 = g..a
//   digits       [4*NUM_DIGITS] published codes, slot i at [4i+3:4i]
//   digit_err    [NUM_DIGITS] published illegal-pattern flags
//   frame_valid  one-cycle pulse on the cycle digits/digit_err update
//   frame_ready  sticky, high once any frame has been published

// One display slot: shadow entry written on capture, copied out on publish.
module seg_scan_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr,
  input  logic [3:0] i_code,
  input  logic       i_err,
  input  logic       i_pub,
  output logic [3:0] o_code,
  output logic       o_err
);
  logic [3:0] r_sh_code;
  logic       r_sh_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_code <= '0;
      r_sh_err  <= 1'b0;
      o_code    <= '0;
      o_err     <= 1'b0;
    end else begin
      // Latest capture wins; shadow is kept across publishes.
      if (i_wr) begin
        r_sh_code <= i_code;
        r_sh_err  <= i_err;
      end
      if (i_pub) begin
        o_code <= r_sh_code;
        o_err  <= r_sh_err;
      end
    end
  end
endmodule

module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   anode,
  input  logic [6:0]              cathode,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    frame_ready
);
  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

  state_t                          r_state, w_nstate;
  logic [SW-1:0]                   r_smp;
  logic [CW-1:0]                   r_cnt, w_ncnt;
  logic [NUM_DIGITS-1:0]           r_seen;
  logic                            r_fv, r_rdy;

  logic [SW-1:0]                   w_in;
  logic                            w_same, w_legal, w_cap, w_pub;
  logic [NUM_DIGITS-1:0]           w_en, w_cap_mask;
  logic [3:0]                      w_code;
  logic                            w_err;
  logic [NUM_DIGITS-1:0][3:0]      w_dig;

  assign w_in   = {anode, cathode};
  assign w_same = (w_in == r_smp);
  // Legal slot: exactly one anode low.
  assign w_en    = ~anode;
  assign w_legal = (w_en != '0) && ((w_en & (w_en - 1'b1)) == '0);

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_cap    = 1'b0;
    case (r_state)
      IDLE: begin
        w_ncnt = '0;
        if (w_legal) w_nstate = SETTLE;
      end
      SETTLE: begin
        if (!w_same) begin
          w_ncnt   = '0;
          w_nstate = w_legal ? SETTLE : IDLE;
        end else if (r_cnt == CW'(STABLE_CYCLES - 1)) begin
          // Counter reaches STABLE_CYCLES on this edge: capture now.
          w_cap    = 1'b1;
          w_ncnt   = '0;
          w_nstate = CAPTURED;
        end else begin
          w_ncnt = r_cnt + CW'(1);
        end
      end
      CAPTURED: begin
        if (!w_same) begin
          w_ncnt   = '0;
          w_nstate = w_legal ? SETTLE : IDLE;
        end
      end
      default: begin
        w_ncnt   = '0;
        w_nstate = IDLE;
      end
    endcase
  end

  // Capture only happens when the incoming sample equals r_smp, so decoding
  // the registered copy is equivalent.
  always_comb begin
    w_err  = 1'b0;
    w_code = 4'd0;
    case (r_smp[6:0])
      7'b1000000: w_code = 4'd0;
      7'b1111001: w_code = 4'd1;
      7'b0100100: w_code = 4'd2;
      7'b0110000: w_code = 4'd3;
      7'b0011001: w_code = 4'd4;
      7'b0010010: w_code = 4'd5;
      7'b0000010: w_code = 4'd6;
      7'b1111000: w_code = 4'd7;
      7'b0000000: w_code = 4'd8;
      7'b0010000: w_code = 4'd9;
      7'b0111111: w_code = 4'd15;
      7'b1111111: w_code = 4'd14;
      default:    w_err  = 1'b1;
    endcase
  end

  // Sampled anode is one-hot-low whenever a capture fires.
  assign w_cap_mask = w_cap ? ~r_smp[SW-1:7] : '0;
  assign w_pub      = &r_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_smp   <= '1;
      r_cnt   <= '0;
      r_seen  <= '0;
      r_fv    <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_smp   <= w_in;
      r_cnt   <= w_ncnt;
      // Clear on publish first, so a coincident capture counts toward the
      // next frame.
      r_seen  <= (w_pub ? '0 : r_seen) | w_cap_mask;
      r_fv    <= w_pub;
      r_rdy   <= r_rdy | w_pub;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
    seg_scan_slot u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_wr   (w_cap_mask[g]),
      .i_code (w_code),
      .i_err  (w_err),
      .i_pub  (w_pub),
      .o_code (w_dig[g]),
      .o_err  (digit_err[g])
    );
  end

  assign digits      = w_dig;
  assign frame_valid = r_fv;
  assign frame_ready = r_rdy;
endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  anode = 4'hF;
  logic [6:0]  cathode = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid, frame_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int fv_cnt = 0;
  int fv0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SM = 7'b0111111, SB = 7'b1111111,
                         SX = 7'b1010101;
  localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011,
                         A3 = 4'b0111, AN = 4'b1111;

  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .anode(anode), .cathode(cathode),
    .digits(digits), .digit_err(digit_err),
    .frame_valid(frame_valid), .frame_ready(frame_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid) fv_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present {an, ca} on n consecutive rising edges; returns 1 time unit
  // after the last of them.
  task automatic drv(input logic [3:0] an, input logic [6:0] ca, input int n);
    anode = an;
    cathode = ca;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic scan
    fv0 = fv_cnt;
    drv(A0, S7, 8); drv(A1, S3, 8); drv(A2, S2, 8); drv(A3, S1, 8);
    chk("basic_fv", fv_cnt - fv0, 1);
    chk("basic_digits", digits, 16'h1237);
    chk("basic_err", digit_err, 4'b0000);
    chk("basic_ready", frame_ready, 1);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    chk("rst_digits", digits, 0);
    chk("rst_err", digit_err, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_ready", frame_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    fv0 = fv_cnt;
    drv(AN, SB, 20);
    chk("idle_fv", fv_cnt - fv0, 0);
    chk("idle_ready", frame_ready, 0);

    // Stability threshold: 4 edges is not enough, 5 captures on the 5th
    fv0 = fv_cnt;
    drv(A0, S5, 4); drv(A1, S2, 8); drv(A2, S3, 8); drv(A3, S4, 8);
    chk("stab4_nofv", fv_cnt - fv0, 0);
    drv(A0, S6, 5);
    chk("stab5_fv_low", frame_valid, 0);
    drv(AN, SB, 1);
    chk("stab5_fv_pulse", frame_valid, 1);
    chk("stab5_digits", digits, 16'h4326);
    drv(AN, SB, 4);
    chk("stab5_fv_once", fv_cnt - fv0, 1);

    // Special codes and illegal pattern
    fv0 = fv_cnt;
    drv(A0, SM, 8); drv(A1, SB, 8); drv(A2, SX, 8); drv(A3, S0, 8);
    chk("spec_fv", fv_cnt - fv0, 1);
    chk("spec_digits", digits, 16'h00EF);
    chk("spec_err", digit_err, 4'b0100);

    // Illegal anodes and overwrite of slot 2
    fv0 = fv_cnt;
    drv(A0, S1, 8); drv(AN, S8, 8); drv(A1, S2, 8); drv(4'b1100, S8, 8);
    drv(A2, S5, 8); drv(A2, S9, 8);
    chk("ovr_nofv", fv_cnt - fv0, 0);
    drv(A3, S3, 8);
    chk("ovr_fv", fv_cnt - fv0, 1);
    chk("ovr_digits", digits, 16'h3921);
    chk("ovr_err", digit_err, 4'b0000);

    // Reset mid-frame discards partial progress
    drv(A0, S1, 8); drv(A1, S2, 8);
    anode = AN; cathode = SB;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    fv0 = fv_cnt;
    chk("mid_ready", frame_ready, 0);
    drv(A0, S8, 8); drv(A1, S8, 8); drv(A2, S8, 8);
    chk("mid_nofv", fv_cnt - fv0, 0);
    drv(A3, S8, 8);
    chk("mid_fv", fv_cnt - fv0, 1);
    chk("mid_digits", digits, 16'h8888);
    chk("mid_ready2", frame_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
